// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with prefetch FIFO, redirect and halt; optional FETCH_PERF_EN adds fetch/stall counters
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halt_ack
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {RUN, HALTED} state_t;
  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [31:0]     pc_mem_q [DEPTH];
  logic [31:0]     word_mem_q [DEPTH];
  logic            push, pop;
  assign imem_a      = pc_q;
  assign instr_valid = cnt_q != '0;
  assign instr       = word_mem_q[rd_q];
  assign instr_pc    = pc_mem_q[rd_q];
  assign halt_ack    = (state_q == HALTED) && (cnt_q == '0);
  // handshake decode, FIFO bookkeeping and halt FSM next state; redirect overrides everything
  always_comb begin
    pop     = instr_valid & instr_ready & ~redirect_valid;
    push    = (state_q == RUN) & ~halt_req & ~redirect_valid & ((cnt_q < FULL) | pop);
    state_d = halt_req ? HALTED : RUN;
    pc_d    = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
    rd_d    = redirect_valid ? '0 : pop ? rd_q + (AW)'(1) : rd_q;
    wr_d    = redirect_valid ? '0 : push ? wr_q + (AW)'(1) : wr_q;
    cnt_d   = redirect_valid ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end
  // FIFO storage: each entry is the fetch PC paired with the word returned for it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        word_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_q]   <= pc_q;
      word_mem_q[wr_q] <= imem_rd;
    end
  end
`ifdef FETCH_PERF_EN
  // performance counters; a stall is a cycle fetch wanted to run but the FIFO was full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      fetch_count <= fetch_count + 32'(push);
      stall_count <= stall_count + 32'((state_q == RUN) & ~halt_req & ~redirect_valid & ~push);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_a, imem_rd, instr, instr_pc, redirect_pc;
  logic        instr_valid, instr_ready, redirect_valid, halt_req, halt_ack;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif
  int checks = 0;
  int failures = 0;

  fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_a(imem_a), .imem_rd(imem_rd),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halt_ack(halt_ack)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    if (a == 32'h8) return 32'h0020_0113;
    if (a == 32'hC) return 32'h0030_0193;
    return ~a;
  endfunction

  assign imem_rd = mem_f(imem_a);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] word);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_word"}, instr, word);
  endtask

  initial begin
    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    tick(2);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_ack", 32'(halt_ack), 32'd0);
    chk("rst_imem_a", imem_a, 32'h0);
    // streaming with decode always ready
    rst_n = 1'b1; instr_ready = 1'b1;
    chk("rel_valid0", 32'(instr_valid), 32'd0);
    tick(); head("s0", 32'h0, 32'h0000_0013);
    chk("s0_imem_a", imem_a, 32'h4);
    tick(); head("s1", 32'h4, 32'h0010_0093);
    tick(); head("s2", 32'h8, 32'h0020_0113);
    tick(); head("s3", 32'hC, 32'h0030_0193);
    // asynchronous reset mid-stream
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_imem_a", imem_a, 32'h0);
`ifdef FETCH_PERF_EN
    chk("async_fcnt", fetch_count, 32'h0);
    chk("async_scnt", stall_count, 32'h0);
`endif
    // fill to DEPTH with decode stalled, then drain with no gaps
    tick(); instr_ready = 1'b0; rst_n = 1'b1;
    tick(10);
    chk("full_imem_a", imem_a, 32'h10);
    head("full_head", 32'h0, 32'h0000_0013);
`ifdef FETCH_PERF_EN
    chk("full_fcnt", fetch_count, 32'd4);
    chk("full_scnt", stall_count, 32'd6);
`endif
    instr_ready = 1'b1;
    tick(); head("d1", 32'h4, 32'h0010_0093);
    tick(); head("d2", 32'h8, 32'h0020_0113);
    tick(); head("d3", 32'hC, 32'h0030_0193);
    tick(); head("d4", 32'h10, 32'hFFFF_FFEF);
    // redirect with three entries queued
    rst_n = 1'b0; instr_ready = 1'b0;
    tick(); rst_n = 1'b1;
    tick(3);
    chk("pre_redir_imem_a", imem_a, 32'hC);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; instr_ready = 1'b1;
    tick(); redirect_valid = 1'b0;
    chk("redir_valid", 32'(instr_valid), 32'd0);
    chk("redir_imem_a", imem_a, 32'h100);
    tick(); head("redir_head", 32'h100, 32'hFFFF_FEFF);
    // redirect near the top of the address space wraps to zero
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect_valid = 1'b0;
    chk("wrap_valid", 32'(instr_valid), 32'd0);
    chk("wrap_imem_a", imem_a, 32'hFFFF_FFF8);
    tick(); head("wrap0", 32'hFFFF_FFF8, 32'h0000_0007);
    tick(); head("wrap1", 32'hFFFF_FFFC, 32'h0000_0003);
    tick(); head("wrap2", 32'h0, 32'h0000_0013);
    // halt with two entries queued; decode drains them
    rst_n = 1'b0; instr_ready = 1'b0;
    tick(); rst_n = 1'b1;
    tick(2);
    halt_req = 1'b1; instr_ready = 1'b1;
    tick(); head("halt_h1", 32'h4, 32'h0010_0093);
    chk("halt_ack1", 32'(halt_ack), 32'd0);
    chk("halt_imem_a1", imem_a, 32'h8);
    tick();
    chk("halt_empty", 32'(instr_valid), 32'd0);
    chk("halt_ack2", 32'(halt_ack), 32'd1);
    tick();
    chk("halt_hold", imem_a, 32'h8);
    chk("halt_ack3", 32'(halt_ack), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick(); redirect_valid = 1'b0;
    chk("halt_redir_a", imem_a, 32'h40);
    chk("halt_redir_ack", 32'(halt_ack), 32'd1);
    chk("halt_redir_valid", 32'(instr_valid), 32'd0);
    halt_req = 1'b0;
    tick();
    chk("resume_ack", 32'(halt_ack), 32'd0);
    chk("resume_valid", 32'(instr_valid), 32'd0);
    chk("resume_a", imem_a, 32'h40);
    tick(); head("resume_head", 32'h40, 32'hFFFF_FFBF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
